// File: rtl/dac_sample_formatter.sv
// dac_sample_formatter: saturates signed sample pairs to 14 bits and codes them for a DDR DAC,
// with hold, ramp and midscale modes selected every cycle by mode_in.
module dac_sample_formatter #(
    parameter int          IN_W       = 16,
    parameter bit          OFFSET_BIN = 1'b0,
    parameter logic [13:0] RAMP_STEP  = 14'd1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic signed [IN_W-1:0] ch0_data_in,
    input  logic signed [IN_W-1:0] ch1_data_in,
    input  logic                   data_valid_in,
    input  logic [1:0]             mode_in,
    input  logic                   sat_clear_in,
    output logic [13:0]            DAC0_out,
    output logic [13:0]            DAC1_out,
    output logic                   valid_out,
    output logic [1:0]             sat_flag_out
);
    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        HOLD     = 2'b01,
        RAMP     = 2'b10,
        MIDSCALE = 2'b11
    } state_t;

    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(8191);
    localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-8192);
    localparam logic [13:0] RAMP_MIN  = 14'h2000;
    localparam logic [13:0] CODE_ZERO = OFFSET_BIN ? 14'h2000 : 14'h0000;

    function automatic logic f_over(input logic signed [IN_W-1:0] x);
        return (x > SAT_HI) || (x < SAT_LO);
    endfunction

    function automatic logic [13:0] f_sat(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] y;
        y = (x > SAT_HI) ? SAT_HI : (x < SAT_LO) ? SAT_LO : x;
        return y[13:0];
    endfunction

    // Offset binary is two's complement with the sign bit inverted.
    function automatic logic [13:0] f_code(input logic [13:0] v);
        return OFFSET_BIN ? {~v[13], v[12:0]} : v;
    endfunction

    state_t      r_state;
    logic        r_entry;
    logic [13:0] r_s1_ch0, r_s1_ch1, r_s2_ch0, r_s2_ch1, r_ramp;
    logic        r_s1_vld, r_s2_vld;

    logic        w_accept;
    logic [1:0]  w_clamp;
    logic [13:0] w_ramp_val, w_ramp_code;

    assign w_accept    = (r_state == NORMAL) && data_valid_in;
    assign w_clamp     = w_accept ? {f_over(ch1_data_in), f_over(ch0_data_in)} : 2'b00;
    assign w_ramp_val  = r_entry ? RAMP_MIN : r_ramp;
    assign w_ramp_code = f_code(w_ramp_val);

    // Samples only advance while the state stays NORMAL, so leaving NORMAL flushes the pipe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= MIDSCALE;
            r_entry      <= 1'b0;
            r_s1_ch0     <= '0;
            r_s1_ch1     <= '0;
            r_s1_vld     <= 1'b0;
            r_s2_ch0     <= '0;
            r_s2_ch1     <= '0;
            r_s2_vld     <= 1'b0;
            r_ramp       <= '0;
            DAC0_out     <= CODE_ZERO;
            DAC1_out     <= CODE_ZERO;
            valid_out    <= 1'b0;
            sat_flag_out <= 2'b00;
        end else begin
            r_state      <= state_t'(mode_in);
            r_entry      <= state_t'(mode_in) != r_state;
            r_s1_vld     <= w_accept;
            if (w_accept) begin
                r_s1_ch0 <= f_sat(ch0_data_in);
                r_s1_ch1 <= f_sat(ch1_data_in);
            end
            r_s2_vld     <= r_s1_vld && (r_state == NORMAL);
            r_s2_ch0     <= r_s1_ch0;
            r_s2_ch1     <= r_s1_ch1;
            sat_flag_out <= w_clamp | (sat_flag_out & {2{~sat_clear_in}});
            case (r_state)
                NORMAL: begin
                    valid_out <= r_s2_vld;
                    if (r_s2_vld) begin
                        DAC0_out <= f_code(r_s2_ch0);
                        DAC1_out <= f_code(r_s2_ch1);
                    end
                end
                HOLD: valid_out <= 1'b0;
                RAMP: begin
                    DAC0_out  <= w_ramp_code;
                    DAC1_out  <= ~w_ramp_code;
                    valid_out <= 1'b1;
                    r_ramp    <= w_ramp_val + RAMP_STEP;
                end
                default: begin
                    DAC0_out  <= CODE_ZERO;
                    DAC1_out  <= CODE_ZERO;
                    valid_out <= r_entry;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_sample_formatter.sv
// tb_dac_sample_formatter: two formatter variants driven in parallel, checked against a queue-based model.
module tb_dac_sample_formatter;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               valid = 1'b0;
    logic               clr = 1'b0;
    logic [1:0]         mode = 2'b11;
    logic signed [15:0] c0 = '0;
    logic signed [15:0] c1 = '0;

    logic [13:0] a_d0, a_d1, b_d0, b_d1;
    logic        a_v, b_v;
    logic [1:0]  a_sf, b_sf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dac_sample_formatter #(.IN_W(16), .OFFSET_BIN(1'b0), .RAMP_STEP(14'd37)) dut_a (
        .clk_in(clk), .rst_in(rst), .ch0_data_in(c0), .ch1_data_in(c1),
        .data_valid_in(valid), .mode_in(mode), .sat_clear_in(clr),
        .DAC0_out(a_d0), .DAC1_out(a_d1), .valid_out(a_v), .sat_flag_out(a_sf));

    dac_sample_formatter #(.IN_W(16), .OFFSET_BIN(1'b1), .RAMP_STEP(14'd1)) dut_b (
        .clk_in(clk), .rst_in(rst), .ch0_data_in(c0), .ch1_data_in(c1),
        .data_valid_in(valid), .mode_in(mode), .sat_clear_in(clr),
        .DAC0_out(b_d0), .DAC1_out(b_d1), .valid_out(b_v), .sat_flag_out(b_sf));

    // Reference model: index 0 is two's complement with step 37, index 1 offset binary with step 1.
    typedef struct {int t; int a; int b;} item_t;
    item_t       pend[$];
    int          cur, prev, ramp_n, t_edge;
    logic [13:0] e0[2], e1[2];
    logic        ev;
    logic [1:0]  esf;

    function automatic logic [13:0] code(input int k, input int v);
        logic [13:0] t;
        t = v[13:0];
        return (k == 1) ? (t ^ 14'h2000) : t;
    endfunction

    function automatic int sat(input int x);
        return x > 8191 ? 8191 : x < -8192 ? -8192 : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        cur = 3;
        prev = 3;
        ramp_n = 0;
        ev = 1'b0;
        esf = 2'b00;
        for (int k = 0; k < 2; k++) begin
            e0[k] = code(k, 0);
            e1[k] = code(k, 0);
        end
    endtask

    task automatic model_edge();
        logic [1:0] clamp;
        clamp = 2'b00;
        t_edge++;
        case (cur)
            0: begin
                ev = 1'b0;
                if (pend.size() > 0 && pend[0].t == t_edge) begin
                    for (int k = 0; k < 2; k++) begin
                        e0[k] = code(k, pend[0].a);
                        e1[k] = code(k, pend[0].b);
                    end
                    ev = 1'b1;
                    void'(pend.pop_front());
                end
                if (valid) begin
                    pend.push_back(item_t'{t_edge + 2, sat(int'(c0)), sat(int'(c1))});
                    clamp = {sat(int'(c1)) != int'(c1), sat(int'(c0)) != int'(c0)};
                end
            end
            1: ev = 1'b0;
            2: begin
                ramp_n = (prev == 2) ? ramp_n + 1 : 0;
                for (int k = 0; k < 2; k++) begin
                    e0[k] = code(k, -8192 + ramp_n * (k == 0 ? 37 : 1));
                    e1[k] = ~e0[k];
                end
                ev = 1'b1;
            end
            default: begin
                for (int k = 0; k < 2; k++) begin
                    e0[k] = code(k, 0);
                    e1[k] = code(k, 0);
                end
                ev = (prev != 3);
            end
        endcase
        if (cur != 0) pend.delete();
        esf = clamp | (esf & ~{2{clr}});
        prev = cur;
        cur = int'(mode);
    endtask

    task automatic check_all();
        chk("a_dac0", a_d0, e0[0]);
        chk("a_dac1", a_d1, e1[0]);
        chk("a_valid", a_v, ev);
        chk("a_sat", a_sf, esf);
        chk("b_dac0", b_d0, e0[1]);
        chk("b_dac1", b_d1, e1[1]);
        chk("b_valid", b_v, ev);
        chk("b_sat", b_sf, esf);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic async_rst();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_async_b_dac0", b_d0, 14'h2000);
    endtask

    initial begin
        t_edge = 0;
        model_reset();
        #2 rst = 1'b1;
        #1 check_all();
        tick();
        tick();
        rst = 1'b0;
        mode = 2'b00;
        tick();
        valid = 1'b1; c0 = 16'sd100; c1 = -16'sd100;
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("n2_a_dac0", a_d0, 14'h0064);
        chk("n2_a_dac1", a_d1, 14'h3F9C);
        chk("n2_a_valid", a_v, 1'b1);
        valid = 1'b1; c0 = 16'sd20000; c1 = -16'sd20000;
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("sat_a_dac0", a_d0, 14'h1FFF);
        chk("sat_a_dac1", a_d1, 14'h2000);
        chk("sat_flags", a_sf, 2'b11);
        tick();
        chk("sat_sticky", b_sf, 2'b11);
        valid = 1'b1; c0 = 16'sd20000; c1 = 16'sd5; clr = 1'b1;
        tick();
        chk("sat_set_wins", a_sf, 2'b01);
        valid = 1'b0;
        tick();
        chk("sat_cleared", a_sf, 2'b00);
        clr = 1'b0;
        mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            c0 = 16'(int'($urandom_range(0, 4000)) - 2000);
            c1 = 16'(int'($urandom_range(0, 4000)) - 2000);
            tick();
        end
        chk("hold_valid", a_v, 1'b0);
        valid = 1'b0; mode = 2'b00;
        tick();
        tick();
        tick();
        valid = 1'b1; c0 = 16'sd7; c1 = -16'sd7;
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("hold_exit_a_dac0", a_d0, 14'h0007);
        mode = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            valid = 1'($urandom);
            c0 = 16'($urandom);
            c1 = 16'($urandom);
            tick();
            if (i == 0) chk("mid_pulse", b_v, 1'b1);
        end
        chk("mid_b_dac0", b_d0, 14'h2000);
        chk("mid_quiet", b_v, 1'b0);
        mode = 2'b10;
        tick();
        tick();
        chk("ramp_first", b_d0, 14'h0000);
        tick();
        chk("ramp_second", b_d0, 14'h0001);
        chk("ramp_not", b_d1, 14'h3FFE);
        for (int i = 0; i < 16383; i++) tick();
        chk("ramp_wrap", b_d0, 14'h0000);
        for (int i = 0; i < 10; i++) tick();
        async_rst();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("ramp_restart", b_d0, 14'h0000);
        for (int i = 0; i < 3000; i++) begin
            rst = 1'b0;
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            valid = 1'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            c0 = 16'(int'($urandom_range(0, 20000)) - 10000);
            c1 = 16'(int'($urandom_range(0, 20000)) - 10000);
            if ($urandom_range(0, 499) == 0) async_rst();
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
